// File: rtl/vblank_scheduler_pkg.sv
// Shared display-timing constants and scheduler types for the vertical-blank
// update sequencer.
//   VBLANK_LINE   : first line after the visible area, where per-frame updates start
//   sched_state_t : scheduler FSM state encoding
package vblank_scheduler_pkg;

  localparam int unsigned SCREEN_V_RES = 480;
  localparam int unsigned X_POS_W      = 10;
  localparam int unsigned Y_POS_W      = 10;
  localparam int unsigned VBLANK_LINE  = SCREEN_V_RES;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StReq,
    StDone
  } sched_state_t;

endpackage

// File: rtl/sched_watchdog.sv
// Per-client acknowledge watchdog: a loadable down-counter with an expire flag.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : reload the counter with TIMEOUT_CYCLES-1
//   run        : count down one step per cycle (saturates at zero)
//   expired    : high while running with the counter at zero
// Only instantiated when VBLANK_SCHED_TIMEOUT_EN is defined.
module sched_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/vblank_scheduler.sv
// Vertical-blank update scheduler. On the first blank line it grants each
// enabled client in index order through a req/ack handshake; if active video
// returns before the sequence completes it aborts with an overrun pulse.
//   clk, rst_n        : clock, asynchronous active-low reset
//   px_en/x_pos/y_pos : pixel strobe and position from the timing generator
//   client_en         : static mask of clients to serve
//   ack               : per-client done pulse, honoured only while own req is high
//   req               : one-hot (or zero) update request
//   busy              : sequence in progress
//   cur_client        : index of client being served (0 when idle)
//   overrun           : 1-cycle pulse, sequence aborted by start of visible frame
//   timeout_err       : 1-cycle pulse, client watchdog expired
//   frame_cnt         : count of completed or aborted sequences (wraps)
// Optional feature: define VBLANK_SCHED_TIMEOUT_EN to enable the per-client
// ack watchdog; otherwise REQ waits indefinitely and timeout_err stays 0.
module vblank_scheduler
  import vblank_scheduler_pkg::*;
#(
  parameter int unsigned N_CLIENTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned FRAME_CNT_W    = 16,
  localparam int unsigned CLI_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   px_en,
  input  logic [X_POS_W-1:0]     x_pos,
  input  logic [Y_POS_W-1:0]     y_pos,
  input  logic [N_CLIENTS-1:0]   client_en,
  input  logic [N_CLIENTS-1:0]   ack,
  output logic [N_CLIENTS-1:0]   req,
  output logic                   busy,
  output logic [CLI_W-1:0]       cur_client,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // One extra bit so the index can reach N_CLIENTS (end-of-list marker).
  localparam int unsigned IDX_W = CLI_W + 1;

  sched_state_t           state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [N_CLIENTS-1:0]   req_q;
  logic                   overrun_q;
  logic                   timeout_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic                 vb_start;
  logic                 vis_start;
  logic                 en_cur;
  logic                 ack_cur;
  logic                 more_en;
  logic                 idx_end;
  logic [N_CLIENTS-1:0] req_onehot;
  logic                 wd_expired;

  assign vb_start  = px_en && (x_pos == '0) && (y_pos == Y_POS_W'(VBLANK_LINE));
  assign vis_start = px_en && (x_pos == '0) && (y_pos == '0);
  assign idx_end   = (idx_q == IDX_W'(N_CLIENTS));

  // Decode the current index: its enable, its qualified ack, its request bit,
  // and whether any enabled client remains after it.
  always_comb begin
    en_cur     = 1'b0;
    ack_cur    = 1'b0;
    more_en    = 1'b0;
    req_onehot = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        en_cur        = client_en[i];
        ack_cur       = ack[i] & req_q[i];
        req_onehot[i] = 1'b1;
      end
      if ((IDX_W'(i) > idx_q) && client_en[i]) begin
        more_en = 1'b1;
      end
    end
  end

`ifdef VBLANK_SCHED_TIMEOUT_EN
  logic wd_load;
  logic wd_run;

  // REQ is only ever entered from SCAN, so reloading throughout SCAN clears
  // the count on every REQ entry.
  assign wd_load = (state_q == StScan);
  assign wd_run  = (state_q == StReq);

  sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wd_load),
    .run    (wd_run),
    .expired(wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      req_q       <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (vb_start) begin
            state_q <= StScan;
            idx_q   <= '0;
          end
        end
        StScan: begin
          if (vis_start) begin
            req_q       <= '0;
            overrun_q   <= 1'b1;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            state_q     <= StIdle;
          end else if (idx_end) begin
            state_q <= StDone;
          end else if (en_cur) begin
            req_q   <= req_onehot;
            state_q <= StReq;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StReq: begin
          if (ack_cur) begin
            // A coincident ack still counts; abort only if work is left over.
            req_q <= '0;
            idx_q <= idx_q + IDX_W'(1);
            if (!vis_start) begin
              state_q <= StScan;
            end else if (!more_en) begin
              state_q <= StDone;
            end else begin
              overrun_q   <= 1'b1;
              frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
              state_q     <= StIdle;
            end
          end else if (vis_start) begin
            req_q       <= '0;
            overrun_q   <= 1'b1;
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            state_q     <= StIdle;
          end else if (wd_expired) begin
            req_q     <= '0;
            timeout_q <= 1'b1;
            idx_q     <= idx_q + IDX_W'(1);
            state_q   <= StScan;
          end
        end
        StDone: begin
          // All clients already served: completes even if video restarts here.
          frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cur_client = '0;
    if ((state_q != StIdle) && !idx_end) begin
      cur_client = idx_q[CLI_W-1:0];
    end
  end

  assign req         = req_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler (N_CLIENTS=4, TIMEOUT_CYCLES=16).
module tb_vblank_scheduler;

  logic        clk;
  logic        rst_n;
  logic        px_en;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic [3:0]  client_en;
  logic [3:0]  ack;
  logic [3:0]  req;
  logic        busy;
  logic [1:0]  cur_client;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] frame_cnt;

  int          n_checks;
  int          n_fails;
  logic        ovr_seen;
  logic        tmo_seen;
  logic [3:0]  req_seen;

  vblank_scheduler #(
    .N_CLIENTS     (4),
    .TIMEOUT_CYCLES(16),
    .FRAME_CNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .px_en      (px_en),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .client_en  (client_en),
    .ack        (ack),
    .req        (req),
    .busy       (busy),
    .cur_client (cur_client),
    .overrun    (overrun),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky record of pulses and requests, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (overrun === 1'b1) ovr_seen = 1'b1;
    if (timeout_err === 1'b1) tmo_seen = 1'b1;
    req_seen = req_seen | req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    px_en = 1'b0;
    x_pos = 10'd7;
    y_pos = 10'd5;
    ack   = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
    step();
    ovr_seen = 1'b0;
    tmo_seen = 1'b0;
    req_seen = 4'b0000;
  endtask

  task automatic pulse_pos(input logic [9:0] y);
    px_en = 1'b1;
    x_pos = 10'd0;
    y_pos = y;
    step();
    px_en = 1'b0;
    x_pos = 10'd7;
    y_pos = 10'd5;
  endtask

  task automatic wait_req(input string tag, input logic [3:0] exp);
    int n = 0;
    while (req !== exp && n < 64) begin
      step();
      n++;
    end
    check(tag, 32'(req), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Wait for client c's request, hold it lat cycles, ack it.
  task automatic serve(input int c, input int lat);
    wait_req($sformatf("req_client%0d", c), 4'(1 << c));
    repeat (lat - 1) step();
    ack = 4'(1 << c);
    step();
    ack = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    client_en = 4'b0000;
    ovr_seen  = 1'b0;
    tmo_seen  = 1'b0;
    req_seen  = 4'b0000;
    do_reset();

    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur", 32'(cur_client), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);

    // All four clients, ack three cycles after each request.
    client_en = 4'b1111;
    pulse_pos(10'd480);
    check("t1_busy_scan", 32'(busy), 32'd1);
    check("t1_req_scan", 32'(req), 32'd0);
    serve(0, 3);
    check("t1_req_dropped", 32'(req), 32'd0);
    check("t1_busy_between", 32'(busy), 32'd1);
    serve(1, 3);
    wait_req("t1_req2", 4'b0100);
    check("t1_cur2", 32'(cur_client), 32'd2);
    serve(2, 3);
    serve(3, 3);
    wait_idle("t1_idle");
    check("t1_frame", 32'(frame_cnt), 32'd1);
    check("t1_no_overrun", 32'(ovr_seen), 32'd0);
    check("t1_req_seen", 32'(req_seen), 32'hF);

    // Sparse mask; a stray vb_start mid-sequence is ignored.
    do_reset();
    client_en = 4'b0101;
    pulse_pos(10'd480);
    serve(0, 1);
    pulse_pos(10'd480);
    serve(2, 1);
    wait_idle("t2_idle");
    check("t2_req_seen", 32'(req_seen), 32'h5);
    check("t2_frame", 32'(frame_cnt), 32'd1);

    // Client 2 silent, visible frame restarts: abort.
    do_reset();
    client_en = 4'b1111;
    pulse_pos(10'd480);
    serve(0, 2);
    serve(1, 2);
    wait_req("t3_req2", 4'b0100);
    step();
    step();
    px_en = 1'b1;
    x_pos = 10'd0;
    y_pos = 10'd0;
    step();
    px_en = 1'b0;
    y_pos = 10'd5;
    check("t3_req_cleared", 32'(req), 32'd0);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_frame", 32'(frame_cnt), 32'd1);
    step();
    check("t3_overrun_pulse", 32'(overrun), 32'd0);

`ifdef VBLANK_SCHED_TIMEOUT_EN
    // Client 1 silent: watchdog skips it after 16 cycles.
    begin
      int n = 0;
      do_reset();
      client_en = 4'b1111;
      pulse_pos(10'd480);
      serve(0, 1);
      wait_req("t4_req1", 4'b0010);
      while (req === 4'b0010 && n < 64) begin
        n++;
        step();
      end
      check("t4_req1_len", 32'(n), 32'd16);
      check("t4_timeout", 32'(timeout_err), 32'd1);
      step();
      check("t4_req2_next", 32'(req), 32'h4);
      serve(2, 1);
      serve(3, 1);
      wait_idle("t4_idle");
      check("t4_no_overrun", 32'(ovr_seen), 32'd0);
      check("t4_frame", 32'(frame_cnt), 32'd1);
    end
`endif

    // Last client's ack coincides with vis_start: normal completion.
    do_reset();
    client_en = 4'b1111;
    pulse_pos(10'd480);
    serve(0, 1);
    serve(1, 1);
    serve(2, 1);
    wait_req("t5_req3", 4'b1000);
    ack   = 4'b1000;
    px_en = 1'b1;
    x_pos = 10'd0;
    y_pos = 10'd0;
    step();
    ack   = 4'b0000;
    px_en = 1'b0;
    y_pos = 10'd5;
    check("t5_req_cleared", 32'(req), 32'd0);
    check("t5_overrun_low", 32'(overrun), 32'd0);
    check("t5_busy_done", 32'(busy), 32'd1);
    step();
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_frame", 32'(frame_cnt), 32'd1);
    check("t5_no_overrun", 32'(ovr_seen), 32'd0);

    // Same coincidence with client 3 still pending: abort.
    do_reset();
    client_en = 4'b1111;
    pulse_pos(10'd480);
    serve(0, 1);
    serve(1, 1);
    wait_req("t5b_req2", 4'b0100);
    ack   = 4'b0100;
    px_en = 1'b1;
    x_pos = 10'd0;
    y_pos = 10'd0;
    step();
    ack   = 4'b0000;
    px_en = 1'b0;
    y_pos = 10'd5;
    check("t5b_overrun", 32'(overrun), 32'd1);
    check("t5b_busy", 32'(busy), 32'd0);
    check("t5b_frame", 32'(frame_cnt), 32'd1);

    // No clients enabled: empty sequence still counts a frame.
    do_reset();
    client_en = 4'b0000;
    pulse_pos(10'd480);
    wait_idle("t7_idle");
    check("t7_frame", 32'(frame_cnt), 32'd1);
    check("t7_no_req", 32'(req_seen), 32'd0);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    client_en = 4'b1111;
    pulse_pos(10'd480);
    wait_req("t6_req0", 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_async", 32'(req), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    check("t6_cur_async", 32'(cur_client), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    pulse_pos(10'd480);
    wait_req("t6_restart_req0", 4'b0001);
    check("t6_restart_cur", 32'(cur_client), 32'd0);
    check("t6_frame", 32'(frame_cnt), 32'd0);
    check("t6_no_pulses", 32'({ovr_seen, tmo_seen}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
